// File: rtl/sqrt_pkg.sv
// Shared sizing and reset constants for the odd-subtraction square-root datapath.
package sqrt_pkg;

    // Default radicand width. It must be even and at least 2.
    localparam int WIDTH_DEF = 8;

    // Reset and reload value of the odd subtrahend D. It is the first odd number.
    localparam int D_INIT = 1;

    // The root of a WIDTH-bit radicand needs half as many bits.
    function automatic int root_width(input int width);
        return width / 2;
    endfunction

endpackage : sqrt_pkg

// File: rtl/sqrt_step.sv
// One iteration of the odd-subtraction root:
//   diff = R - D
//   next D = D + 2
//   Q advances only while diff stays non-negative.
module sqrt_step
    import sqrt_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH:0]                 r_i,
    input  logic [root_width(WIDTH)+1:0]   d_i,
    input  logic [root_width(WIDTH)-1:0]   q_i,
    output logic [WIDTH:0]                 r_o,
    output logic [root_width(WIDTH)+1:0]   d_o,
    output logic [root_width(WIDTH)-1:0]   q_o,
    output logic                           neg_o
);

    localparam int ROOT_W = root_width(WIDTH);

    // One guard bit above the remainder keeps the sign of R - D exact.
    logic signed [WIDTH+1:0] diff;

    // Subtract the current odd number. A strictly negative result ends the run.
    always_comb begin
        diff  = $signed({r_i[WIDTH], r_i}) - $signed({{(WIDTH - ROOT_W){1'b0}}, d_i});
        neg_o = diff[WIDTH+1];
        r_o   = diff[WIDTH:0];
        d_o   = d_i + (ROOT_W + 2)'(2);
        q_o   = neg_o ? q_i : q_i + ROOT_W'(1);
    end

endmodule : sqrt_step

// File: rtl/sqrt_datapath.sv
// Square-root datapath register file.
// A load from the control path seeds R with x.
// Each enabled cycle then subtracts the next odd number, until the remainder goes negative.
module sqrt_datapath
    import sqrt_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [WIDTH-1:0]              x_i,
    input  logic                          wr_input_i,
    input  logic                          en_pipe_i,
    output logic                          N_o,
    output logic                          done_o,
    output logic [root_width(WIDTH)-1:0]  root_o
);

    localparam int ROOT_W = root_width(WIDTH);
    localparam logic [ROOT_W+1:0] D_RST = (ROOT_W + 2)'(D_INIT);

    logic [WIDTH:0]    r_q,   r_d;
    logic [ROOT_W+1:0] d_q,   d_d;
    logic [ROOT_W-1:0] q_q,   q_d;
    logic              neg_q, neg_d;

    logic [WIDTH:0]    step_r;
    logic [ROOT_W+1:0] step_d;
    logic [ROOT_W-1:0] step_q;
    logic              step_neg;

    sqrt_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .r_i   (r_q),
        .d_i   (d_q),
        .q_i   (q_q),
        .r_o   (step_r),
        .d_o   (step_d),
        .q_o   (step_q),
        .neg_o (step_neg)
    );

    // Priority is load first, then iterate while not yet negative, otherwise hold.
    always_comb begin
        // NOTE: every next-state signal gets its hold value first, so no path leaves one unassigned and no latch is inferred.
        r_d   = r_q;
        d_d   = d_q;
        q_d   = q_q;
        neg_d = neg_q;
        if (wr_input_i) begin
            r_d   = {1'b0, x_i};
            d_d   = D_RST;
            q_d   = '0;
            neg_d = 1'b0;
        end else if (en_pipe_i && !neg_q) begin
            // The control FSM holds en_pipe one cycle past N=1. The sticky NEG flag masks that extra cycle.
            r_d   = step_r;
            d_d   = step_d;
            q_d   = step_q;
            neg_d = step_neg;
        end
    end

    // State registers. An asynchronous reset abandons any partial result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q   <= '0;
            d_q   <= D_RST;
            q_q   <= '0;
            neg_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every register sample pre-edge values, so statement order does not matter.
            r_q   <= r_d;
            d_q   <= d_d;
            q_q   <= q_d;
            neg_q <= neg_d;
        end
    end

    // The flags and the result come straight from registers, with no combinational path from the inputs.
    assign N_o    = neg_q;
    assign done_o = neg_q;
    assign root_o = q_q;

endmodule : sqrt_datapath

// File: tb/tb_sqrt_datapath.sv
// Directed bench for sqrt_datapath. All expected values are hand-computed.
module tb_sqrt_datapath;

    localparam int WIDTH  = 8;
    localparam int ROOT_W = WIDTH / 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [WIDTH-1:0]  x_i = '0;
    logic              wr_input_i = 1'b0;
    logic              en_pipe_i = 1'b0;
    logic              N_o;
    logic              done_o;
    logic [ROOT_W-1:0] root_o;

    int checks = 0;
    int errors = 0;

    sqrt_datapath #(
        .WIDTH (WIDTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .x_i        (x_i),
        .wr_input_i (wr_input_i),
        .en_pipe_i  (en_pipe_i),
        .N_o        (N_o),
        .done_o     (done_o),
        .root_o     (root_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    // Advance one clock. Sampling happens 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [WIDTH-1:0] x);
        x_i        = x;
        wr_input_i = 1'b1;
        en_pipe_i  = 1'b0;
        step();
        wr_input_i = 1'b0;
    endtask

    // Iterate until N_o rises or the budget runs out. Return the number of enabled cycles used.
    task automatic iterate(output int cycles);
        cycles    = 0;
        en_pipe_i = 1'b1;
        while (!N_o && cycles < 40) begin
            step();
            cycles++;
        end
        en_pipe_i = 1'b0;
    endtask

    task automatic run(input string tag, input logic [WIDTH-1:0] x, input int exp_root, input int exp_cycles);
        int cyc;
        load(x);
        iterate(cyc);
        check({tag, "_cycles"}, cyc, exp_cycles);
        check({tag, "_root"}, root_o, exp_root);
        check({tag, "_done"}, done_o, 1);
    endtask

    initial begin
        int cyc;

        // Reset state
        #2;
        check("rst_N", N_o, 0);
        check("rst_done", done_o, 0);
        check("rst_root", root_o, 0);
        rst_n = 1'b1;
        step();

        // x=9: remainder sequence 8, 5, 0, -7; N_o rises on the 4th enabled cycle
        load(8'd9);
        check("x9_load_N", N_o, 0);
        en_pipe_i = 1'b1;
        step();
        check("x9_r1", 32'($signed(dut.r_q)), 8);
        check("x9_q1", root_o, 1);
        step();
        check("x9_r2", 32'($signed(dut.r_q)), 5);
        check("x9_q2", root_o, 2);
        step();
        check("x9_r3", 32'($signed(dut.r_q)), 0);
        check("x9_q3", root_o, 3);
        check("x9_N3", N_o, 0);
        step();
        check("x9_r4", 32'($signed(dut.r_q)), -7);
        check("x9_q4", root_o, 3);
        check("x9_N4", N_o, 1);
        en_pipe_i = 1'b0;

        // Boundary radicands
        run("x0", 8'd0, 0, 1);
        run("x1", 8'd1, 1, 2);
        run("x255", 8'd255, 15, 16);
        run("x224", 8'd224, 14, 15);

        // x=50: extra enabled cycles after N_o=1 must be ignored
        run("x50", 8'd50, 7, 8);
        en_pipe_i = 1'b1;
        for (int i = 0; i < 5; i++) step();
        en_pipe_i = 1'b0;
        check("x50_hold_root", root_o, 7);
        check("x50_hold_N", N_o, 1);

        // A load that arrives together with en_pipe_i mid-run takes priority
        load(8'd16);
        en_pipe_i = 1'b1;
        step();
        step();
        check("x16_mid_q", root_o, 2);
        x_i        = 8'd16;
        wr_input_i = 1'b1;
        step();
        wr_input_i = 1'b0;
        check("x16_reload_q", root_o, 0);
        check("x16_reload_N", N_o, 0);
        en_pipe_i = 1'b0;
        iterate(cyc);
        check("x16_cycles", cyc, 5);
        check("x16_root", root_o, 4);

        // An asynchronous reset mid-iteration clears the outputs before the next edge
        load(8'd200);
        en_pipe_i = 1'b1;
        step();
        step();
        step();
        en_pipe_i = 1'b0;
        check("x200_pre_q", root_o, 3);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_root", root_o, 0);
        check("arst_N", N_o, 0);
        check("arst_done", done_o, 0);
        #1;
        rst_n = 1'b1;
        step();
        run("x200", 8'd200, 14, 15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_sqrt_datapath

// File: doc/sqrt_datapath.md
Name: sqrt_datapath

Overview:
- Iterative integer square-root datapath using odd-number subtraction: floor(sqrt(x)) is the number of odd numbers 1, 3, 5, … that can be subtracted from x before the remainder goes negative.
- Sits directly downstream of the square-root control FSM.
- Consumes that FSM's input-load strobe (wr_input_i) and pipeline enable (en_pipe_i).
- Produces the negative flag (N_o) that drives the FSM's S1→S2 transition, plus the final root.

Parameters:
- WIDTH, 8, bit width of the unsigned radicand x_i; must be even and ≥ 2.
- ROOT_W, WIDTH/2, bit width of the root result (derived; not overridable).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset; asserting it immediately forces all registers to reset values.
- x_i  input  WIDTH  unsigned radicand; sampled only when wr_input_i=1.
- wr_input_i  input  1  load strobe from control path.
- en_pipe_i  input  1  iteration enable from control path.
- N_o  output  1  remainder-negative flag, registered; feeds control path.
- done_o  output  1  result valid; equals N_o.
- root_o  output  ROOT_W  floor(sqrt(x)); valid when done_o=1.

Behaviour:
- Internal registers:
  - R: signed remainder, WIDTH+1 bits.
  - D: odd subtrahend, ROOT_W+2 bits.
  - Q: root count, ROOT_W bits.
  - NEG: sticky negative flag.
- Reset (async, rst_n=0): R=0, D=1, Q=0, NEG=0; so N_o=0, done_o=0, root_o=0. Reset mid-iteration aborts with no partial result retained.
- Load (wr_input_i=1): R<=zero-extended x_i, D<=1, Q<=0, NEG<=0. Load has priority over en_pipe_i when both are high. Load also restarts from any state, including NEG=1.
- Iterate (en_pipe_i=1, wr_input_i=0, NEG=0):
  - diff = R - D, computed in WIDTH+2 signed bits.
  - R<=diff, truncated to WIDTH+1 bits.
  - D<=D+2.
  - If diff ≥ 0: Q<=Q+1.
  - If diff < 0: NEG<=1 and Q holds.
- Hold:
  - en_pipe_i=1 with NEG=1 is ignored. Required because the control FSM keeps en_pipe high for one extra cycle after it observes N=1.
  - With both strobes low, all registers hold.
- N_o = NEG, registered with no combinational path from inputs. done_o = NEG. root_o = Q.
- Latency: floor(sqrt(x))+1 enabled cycles after the load cycle, until N_o rises. Example: x=9 gives 4 iterations.
- Width rules:
  - x=2^WIDTH-1 gives Q max = 2^ROOT_W-1 without overflow.
  - D max = 2^(ROOT_W+1)+1 fits ROOT_W+2 bits.
  - R min = -(2^(ROOT_W+1)+1) fits WIDTH+1 signed bits.
- Boundary cases:
  - x=0: first iteration gives diff=-1, so NEG=1 and root_o=0 after 1 cycle.
  - x=1: root_o=1 after 2 cycles.
  - Perfect squares: R passes through exactly 0 and Q counts that step. Only a strictly negative diff sets NEG.

Decomposition:
- Package sqrt_pkg: WIDTH default, ROOT_W derivation, and the reset constant for D (=1).
- One natural sub-module: sqrt_step, a combinational diff/sign/next-D/next-Q computation.
- sqrt_datapath holds the registers and priority muxing.
- Top level pairs sqrt_datapath with the existing control FSM (wr_input_o→wr_input_i, en_pipe_o→en_pipe_i, N_o→N_i).

Test Plan:
- Reset then load x=9, drive en_pipe_i continuously: N_o rises after 4 enabled cycles, root_o=3, remainder sequence 8,5,0,-7.
- Load x=0 and x=1 (separate runs): root_o=0 after 1 cycle; root_o=1 after 2 cycles.
- WIDTH=8, x=255: root_o=15 after 16 cycles, no overflow. Then x=224: root_o=14.
- Keep en_pipe_i=1 for 5 extra cycles after N_o=1 with x=50: root_o stays 7, N_o stays 1.
- Assert wr_input_i and en_pipe_i together mid-run with x=16: load wins, Q=0, N_o=0. Completion gives root_o=4.
- Pulse rst_n low between clock edges during x=200 iteration: outputs go to 0 immediately without waiting for a clock edge. A reload of x=200 then gives root_o=14.
